// File: rtl/vec_capture_pkg.sv
// Shared types for the vector-counter capture scheduler.
//   state_t : scheduler phase (IDLE, RUN, STOP)
//   tag_t   : snapshot source tag carried with each FIFO entry
//   DROP_W  : width of the saturating drop counter
package vec_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TAG_PERIODIC = 2'd0,
    TAG_MANUAL   = 2'd1,
    TAG_FINAL    = 2'd2
  } tag_t;

  localparam int DROP_W = 8;

endpackage

// File: rtl/vec_capture_fifo.sv
// Synchronous FIFO holding tagged snapshots.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears pointers only)
//   push     : write wdata (ignored when full unless a pop happens this cycle)
//   pop      : discard head entry (ignored when empty)
//   wdata    : entry to write
//   head     : current head entry, zero when empty (combinational read)
//   full     : DEPTH entries held
//   empty    : no entries held
module vec_capture_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vec_capture_ctrl.sv
// Capture scheduler for a free-running vector counter.
// Owns the counter, a periodic timer and the IDLE/RUN/STOP sequencer, and
// snapshots the counter on periodic, manual and final (stop) triggers into
// a FIFO drained by a valid/ready consumer.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : 1 = run counter and timer, 0 = stop
//   sw_req    : single-cycle manual capture request
//   cnt       : current counter value
//   rd_valid/rd_ready/rd_data/rd_tag : FIFO head handshake
//   full      : FIFO holds DEPTH entries
//   drop_cnt  : saturating count of triggers lost to a full FIFO
// Build option: define VEC_CAPTURE_DROP_CNT_EN to implement drop_cnt;
// otherwise drop_cnt is tied to zero.
module vec_capture_ctrl
  import vec_capture_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sw_req,
  output logic [WIDTH-1:0]  cnt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [1:0]        rd_tag,
  output logic              full,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int TW = $clog2(PERIOD);

  state_t           state;
  state_t           state_nxt;
  logic [TW-1:0]    timer;
  logic             trig_periodic;
  logic             trig_final;
  logic             push_req;
  tag_t             push_tag;
  logic             pop;
  logic             accept;
  logic             empty;
  logic [WIDTH+1:0] head;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign trig_periodic = (state == RUN) && (timer == TW'(PERIOD - 1));
  assign trig_final    = (state == STOP);
  assign push_req      = trig_periodic || sw_req || trig_final;

  // Coincident triggers collapse into a single entry with the strongest tag.
  always_comb begin
    push_tag = TAG_PERIODIC;
    if (trig_final)  push_tag = TAG_FINAL;
    else if (sw_req) push_tag = TAG_MANUAL;
  end

  assign pop    = rd_valid && rd_ready;
  assign accept = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        cnt   <= cnt + WIDTH'(1);
        timer <= trig_periodic ? '0 : timer + TW'(1);
      end else if (state == IDLE && en) begin
        timer <= '0;
      end
    end
  end

  vec_capture_fifo #(
    .WIDTH (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .wdata ({push_tag, cnt}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign rd_valid = !empty;
  assign rd_data  = head[WIDTH-1:0];
  assign rd_tag   = head[WIDTH+1:WIDTH];

`ifdef VEC_CAPTURE_DROP_CNT_EN
  logic              drop;
  logic [DROP_W-1:0] drop_q;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

  assign drop = push_req && !accept;

  always_ff @(posedge clk) begin
    if (rst)       drop_q <= '0;
    else if (drop) drop_q <= sat_inc(drop_q);
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_vec_capture_ctrl.sv
module tb_vec_capture_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             sw_req;
  logic [WIDTH-1:0] cnt;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [1:0]       rd_tag;
  logic             full;
  logic [7:0]       drop_cnt;

  vec_capture_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sw_req   (sw_req),
    .cnt      (cnt),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .full     (full),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model: mode 0 idle, 1 running, 2 stopping.
  int               m_mode  = 0;
  logic [WIDTH-1:0] m_cnt   = '0;
  int               m_timer = 0;
  int               m_drop  = 0;
  logic [WIDTH-1:0] mq_d[$];
  logic [1:0]       mq_t[$];
  bit               m_per;
  bit               m_trig;
  logic [1:0]       m_tag;

  // Log of entries the consumer actually took.
  logic [WIDTH-1:0] log_d[$];
  logic [1:0]       log_t[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef VEC_CAPTURE_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (log_d.size() > i) ? log_d[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_tag(input int i);
    return (log_t.size() > i) ? 32'(log_t[i]) : 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_cnt = '0; m_timer = 0; m_drop = 0;
      mq_d.delete(); mq_t.delete();
    end else begin
      m_per  = (m_mode == 1) && (m_timer == PERIOD - 1);
      m_trig = m_per || sw_req || (m_mode == 2);
      m_tag  = (m_mode == 2) ? 2'd2 : (sw_req ? 2'd1 : 2'd0);
      if (mq_d.size() > 0 && rd_ready) begin
        void'(mq_d.pop_front());
        void'(mq_t.pop_front());
      end
      if (m_trig) begin
        if (mq_d.size() < DEPTH) begin
          mq_d.push_back(m_cnt);
          mq_t.push_back(m_tag);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      case (m_mode)
        0: if (en) begin m_mode = 1; m_timer = 0; end
        1: begin
          m_cnt   = m_cnt + 1;
          m_timer = m_per ? 0 : m_timer + 1;
          if (!en) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cnt",      cnt,         m_cnt);
      check("rd_valid", 32'(rd_valid), 32'(mq_d.size() > 0));
      check("rd_data",  rd_data,     (mq_d.size() > 0) ? mq_d[0] : '0);
      check("rd_tag",   32'(rd_tag), (mq_t.size() > 0) ? 32'(mq_t[0]) : 32'd0);
      check("full",     32'(full),   32'(mq_d.size() == DEPTH));
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
      if (rd_valid && rd_ready) begin
        log_d.push_back(rd_data);
        log_t.push_back(rd_tag);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sw_req = 1'b0;
    step(2);
    rst = 1'b0;
    log_d.delete(); log_t.delete();
  endtask

  int drop_before;

  initial begin
    rst = 1'b1; en = 1'b0; sw_req = 1'b0; rd_ready = 1'b0;
    step(2);
    chk_on = 1'b1;
    do_reset();
    check("reset_cnt",   cnt, 0);
    check("reset_valid", 32'(rd_valid), 0);
    check("reset_full",  32'(full), 0);
    check("reset_drop",  32'(drop_cnt), 0);

    // Free run with a ready consumer.
    rd_ready = 1'b1; en = 1'b1;
    step(26);
    check("run_cnt25", cnt, 25);
    check("run_n",     32'(log_d.size()), 2);
    check("run_d0",    log_data(0), 9);
    check("run_t0",    log_tag(0), 0);
    check("run_d1",    log_data(1), 19);
    check("run_t1",    log_tag(1), 0);
    en = 1'b0;
    step(4);

    // Manual request coinciding with the periodic trigger.
    do_reset();
    rd_ready = 1'b1; en = 1'b1;
    step(10);
    check("sw_cnt9", cnt, 9);
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    step(3);
    check("sw_n",    32'(log_d.size()), 1);
    check("sw_d0",   log_data(0), 9);
    check("sw_t0",   log_tag(0), 1);
    check("sw_drop", 32'(drop_cnt), 0);
    en = 1'b0;
    step(3);

    // Stop after a short run yields a final snapshot.
    do_reset();
    rd_ready = 1'b1; en = 1'b1;
    step(12);
    en = 1'b0;
    step(4);
    check("stop_n",   32'(log_d.size()), 2);
    check("stop_d0",  log_data(0), 9);
    check("stop_t0",  log_tag(0), 0);
    check("stop_d1",  log_data(1), 12);
    check("stop_t1",  log_tag(1), 2);
    check("stop_cnt", cnt, 12);

    // One-cycle en drop: RUN->STOP->IDLE->RUN with one final entry.
    log_d.delete(); log_t.delete();
    en = 1'b1;
    step(5);
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(3);
    check("pulse_n",  32'(log_d.size()), 1);
    check("pulse_d0", log_data(0), 17);
    check("pulse_t0", log_tag(0), 2);
    en = 1'b0;
    step(3);

    // Stalled consumer: FIFO fills and later triggers are dropped.
    do_reset();
    rd_ready = 1'b0; en = 1'b1;
    step(61);
    check("fill_full",  32'(full), 1);
    check("fill_valid", 32'(rd_valid), 1);
    check("fill_head",  rd_data, 9);
    check("fill_cnt",   cnt, 60);
`ifdef VEC_CAPTURE_DROP_CNT_EN
    check("fill_drop",  32'(drop_cnt), 2);
`else
    check("fill_drop",  32'(drop_cnt), 0);
`endif
    drop_before = int'(drop_cnt);

    // Pop and push in the same cycle on a full FIFO.
    step(9);
    check("pp_cnt69", cnt, 69);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    check("pp_full", 32'(full), 1);
    check("pp_drop", 32'(drop_cnt), 32'(drop_before));
    check("pp_head", rd_data, 19);
    check("pp_pop",  log_data(0), 9);
    en = 1'b0;
    step(3);

    // Reset mid-run with an entry queued.
    do_reset();
    rd_ready = 1'b0; en = 1'b1;
    step(15);
    check("mid_valid", 32'(rd_valid), 1);
    check("mid_cnt",   cnt, 14);
    rst = 1'b1;
    step(1);
    rst = 1'b0; en = 1'b0;
    check("rst_cnt",   cnt, 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data",  rd_data, 0);
    check("rst_tag",   32'(rd_tag), 0);
    check("rst_full",  32'(full), 0);
    check("rst_drop",  32'(drop_cnt), 0);

    // Manual request while idle.
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
    check("idle_sw_valid", 32'(rd_valid), 1);
    check("idle_sw_tag",   32'(rd_tag), 1);
    check("idle_sw_data",  rd_data, 0);
    rd_ready = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
